regfile_access_ctrl: RTL
========================

Name: regfile_access_ctrl

Overview:
- Initiator side of the PIC16C5x file-register write/read interface.
- Accepts one byte-oriented file-register operation per request and sequences it over four Q-phase states:
  - present the address;
  - sample the file data;
  - compute the result and flags;
  - issue the write command.
- Owns the W working register.
- Drives writeCommand/fileAddr/writeDataIn/statusIn of the register file.

Parameters:
- DATA_WIDTH, 8, datapath width (W, file data, status).
- ADDR_WIDTH, 5, file address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- reqValid  in  1  operation request valid.
- reqReady  out  1  block can accept a request this cycle.
- reqOp  in  4  opcode (see Behaviour).
- reqAddr  in  ADDR_WIDTH  file address (0 = INDF, indirect through FSR inside register file).
- reqDest  in  1  0: result to W, 1: result to file.
- reqBit  in  3  bit index for BCF/BSF.
- wLoadEn  in  1  direct W load strobe (literal path).
- wLoadData  in  DATA_WIDTH  W load value.
- regfileIn  in  DATA_WIDTH  read data from register file for fileAddr.
- statusCur  in  DATA_WIDTH  current STATUS from register file.
- writeCommand  out  3  000 none, 001 status only, 010 file write, 011 file write + status, 100 FSR write (unused here).
- fileAddr  out  ADDR_WIDTH  file address.
- writeDataIn  out  DATA_WIDTH  write data.
- statusIn  out  DATA_WIDTH  new STATUS value.
- wOut  out  DATA_WIDTH  W register.
- done  out  1  one-cycle pulse at writeback.
- err  out  1  one-cycle pulse with done for an illegal opcode.

Behaviour:
- Reset values:
  - Outputs: writeCommand=000, fileAddr=0, writeDataIn=0, statusIn=0, done=0, err=0.
  - W=0, state=IDLE, reqReady=1.
- States: IDLE -> Q1 -> Q2 -> Q3 -> Q4 -> (IDLE, or Q1 if a request is accepted in Q4).
- Handshake:
  - Transfer occurs when reqValid && reqReady.
  - reqReady=1 in IDLE and in Q4, 0 in Q1–Q3.
  - Request fields are captured at transfer; they need not be held afterwards.
- Q1: fileAddr driven from the captured address. fileAddr holds that value through Q4.
- Q2: regfileIn and statusCur are sampled into the operand register (f) and status copy (s).
- Q3: result r and flags are computed and registered. C=bit0, DC=bit1, Z=bit2.
- Q4: writeCommand, writeDataIn, statusIn and done are valid for exactly one cycle. All other cycles have writeCommand=000.
- Latency: transfer to done = 4 cycles. Back-to-back throughput is one op per 4 cycles.
- Opcodes:
  - 0 MOVWF: r=W, always to file, no flags.
  - 1 CLR: r=0, Z=1.
  - 2 MOVF: r=f, Z.
  - 3 ADDWF: r=f+W, C=carry out, DC=carry from bit 3, Z.
  - 4 SUBWF: r=f-W, C=1 if no borrow, DC=1 if no nibble borrow, Z.
  - 5 ANDWF, 6 IORWF, 7 XORWF: Z only.
  - 8 INCF, 9 DECF: mod 2^DATA_WIDTH, Z only.
  - A COMF: Z.
  - B SWAPF: nibbles swapped, no flags.
  - C RLF: {f[6:0],C} with C=f[7].
  - D RRF: {C,f[7:1]} with C=f[0].
  - E BCF, F BSF: see Optional Feature.
- statusIn = statusCur sampled in Q2, with only the affected flag bits replaced. Bits 7:3 pass through.
- Writeback command selection:
  - dest=file and flags affected: 011.
  - dest=file, no flags: 010.
  - dest=W and flags affected: 001.
  - dest=W, no flags: 000. W updates in Q4.
- dest=file to address 3 (STATUS) with a flag-affecting op: issue 010 only. The data write wins and flags are discarded.
- wLoadEn loads W in any state. If it coincides with a Q4 W-writeback, the writeback wins.
- Operand W for computation is W as sampled in Q3.
- Reset mid-operation: the block returns to IDLE immediately and no writeCommand is issued.

Optional Feature:
- RFC_BITOPS_EN defined:
  - BCF clears f[reqBit]; BSF sets f[reqBit].
  - Always written to file (010), no flags.
- RFC_BITOPS_EN undefined:
  - Opcodes E/F are illegal: writeCommand=000 and done=1 with err=1 in Q4. W and file are unchanged.
  - reqBit is ignored.

Test Plan:
- Reset, then wLoadEn with 0x3C, then MOVWF addr 0x08 -> Q4: writeCommand=010, fileAddr=0x08, writeDataIn=0x3C, done=1, exactly 4 cycles after transfer.
- W=0x01, regfileIn=0xFF, ADDWF addr 0x0A dest=1, statusCur=0x18 -> writeCommand=011, writeDataIn=0x00, statusIn=0x1F (Z=1, DC=1, C=1).
- W=0x05, f=0x03, SUBWF dest=0 -> writeCommand=001, W=0xFE, C=0, DC=0, Z=0.
- Back-to-back requests with reqValid held -> reqReady low in Q1–Q3; second done exactly 4 cycles after first done. Reset asserted in Q2 -> no write, reqReady=1.
- RRF f=0x01, C=0, dest=1 -> writeDataIn=0x00, statusIn C=1, Z unchanged. Concurrent wLoadEn in Q4 of MOVF dest=0 -> W takes the MOVF result.
- BSF addr 0x0F, reqBit=7, f=0x00 -> with macro: writeCommand=010, data=0x80. Without macro: writeCommand=000, err=1.

Source files
------------

// File: rtl/regfile_access_ctrl_if.sv
// Request and register-file bus bundle for regfile_access_ctrl.
// The master modport is the controller side; slave is the requester and register file.
interface regfile_access_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
);
    // request channel
    logic                  reqValid;
    logic                  reqReady;
    logic [3:0]            reqOp;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic                  reqDest;
    logic [2:0]            reqBit;

    // register file channel
    logic [DATA_WIDTH-1:0] regfileIn;
    logic [DATA_WIDTH-1:0] statusCur;
    logic [2:0]            writeCommand;
    logic [ADDR_WIDTH-1:0] fileAddr;
    logic [DATA_WIDTH-1:0] writeDataIn;
    logic [DATA_WIDTH-1:0] statusIn;

    modport master (
        input  reqValid, reqOp, reqAddr, reqDest, reqBit, regfileIn, statusCur,
        output reqReady, writeCommand, fileAddr, writeDataIn, statusIn
    );

    modport slave (
        output reqValid, reqOp, reqAddr, reqDest, reqBit, regfileIn, statusCur,
        input  reqReady, writeCommand, fileAddr, writeDataIn, statusIn
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// PIC16C5x file-register access controller: sequences one byte-oriented
// operation over Q1..Q4 and owns the W register.
// Optional macro RFC_BITOPS_EN enables BCF/BSF; otherwise opcodes E/F are illegal.
module regfile_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_access_ctrl_if.master bus,
    input  logic                  wLoadEn,
    input  logic [DATA_WIDTH-1:0] wLoadData,
    output logic [DATA_WIDTH-1:0] wOut,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned NIB     = DATA_WIDTH / 2;
    localparam int unsigned FLAG_C  = 0;
    localparam int unsigned FLAG_DC = 1;
    localparam int unsigned FLAG_Z  = 2;

    localparam logic [2:0] MASK_C   = 3'b001;
    localparam logic [2:0] MASK_Z   = 3'b100;
    localparam logic [2:0] MASK_ALL = 3'b111;

    localparam logic [2:0] CMD_NONE        = 3'b000;
    localparam logic [2:0] CMD_STATUS      = 3'b001;
    localparam logic [2:0] CMD_FILE        = 3'b010;
    localparam logic [2:0] CMD_FILE_STATUS = 3'b011;

    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(3);

    localparam logic [3:0] OP_MOVWF = 4'h0;
    localparam logic [3:0] OP_CLR   = 4'h1;
    localparam logic [3:0] OP_MOVF  = 4'h2;
    localparam logic [3:0] OP_ADDWF = 4'h3;
    localparam logic [3:0] OP_SUBWF = 4'h4;
    localparam logic [3:0] OP_ANDWF = 4'h5;
    localparam logic [3:0] OP_IORWF = 4'h6;
    localparam logic [3:0] OP_XORWF = 4'h7;
    localparam logic [3:0] OP_INCF  = 4'h8;
    localparam logic [3:0] OP_DECF  = 4'h9;
    localparam logic [3:0] OP_COMF  = 4'hA;
    localparam logic [3:0] OP_SWAPF = 4'hB;
    localparam logic [3:0] OP_RLF   = 4'hC;
    localparam logic [3:0] OP_RRF   = 4'hD;
`ifdef RFC_BITOPS_EN
    localparam logic [3:0] OP_BCF   = 4'hE;
    localparam logic [3:0] OP_BSF   = 4'hF;
`endif

    typedef enum logic [2:0] {IDLE, Q1, Q2, Q3, Q4} state_t;

    state_t                state;
    logic                  ready_q;
    logic [3:0]            op_q;
    logic                  dest_q;
    logic [DATA_WIDTH-1:0] f_q;
    logic [DATA_WIDTH-1:0] s_q;
    logic [DATA_WIDTH-1:0] w_q;
    logic                  w_wb_q;
`ifdef RFC_BITOPS_EN
    logic [2:0]            bit_q;
`else
    logic                  unused_req_bit;
    assign unused_req_bit = ^bus.reqBit;
`endif

    logic                  accept;
    logic [DATA_WIDTH:0]   add_full;
    logic [DATA_WIDTH:0]   sub_full;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [2:0]            alu_mask;
    logic [2:0]            alu_flags;
    logic                  alu_to_file;
    logic                  alu_illegal;
    logic [DATA_WIDTH-1:0] status_new;

    assign accept       = ready_q & bus.reqValid;
    assign bus.reqReady = ready_q;
    assign wOut         = w_q;

    // Result and flag computation from the captured operand, status copy and W.
    always_comb begin
        alu_res     = '0;
        alu_mask    = '0;
        alu_flags   = '0;
        alu_to_file = dest_q;
        alu_illegal = 1'b0;
        add_full    = {1'b0, f_q} + {1'b0, w_q};
        sub_full    = {1'b0, f_q} - {1'b0, w_q};
        case (op_q)
            OP_MOVWF: begin alu_res = w_q; alu_to_file = 1'b1; end
            OP_CLR:   begin alu_res = '0; alu_mask = MASK_Z; end
            OP_MOVF:  begin alu_res = f_q; alu_mask = MASK_Z; end
            OP_ADDWF: begin
                alu_res            = add_full[DATA_WIDTH-1:0];
                alu_mask           = MASK_ALL;
                alu_flags[FLAG_C]  = add_full[DATA_WIDTH];
                // carry into bit 4 recovered from the sum bit
                alu_flags[FLAG_DC] = f_q[4] ^ w_q[4] ^ add_full[4];
            end
            OP_SUBWF: begin
                alu_res            = sub_full[DATA_WIDTH-1:0];
                alu_mask           = MASK_ALL;
                alu_flags[FLAG_C]  = ~sub_full[DATA_WIDTH];
                // borrow into bit 4 recovered from the difference bit
                alu_flags[FLAG_DC] = ~(f_q[4] ^ w_q[4] ^ sub_full[4]);
            end
            OP_ANDWF: begin alu_res = f_q & w_q; alu_mask = MASK_Z; end
            OP_IORWF: begin alu_res = f_q | w_q; alu_mask = MASK_Z; end
            OP_XORWF: begin alu_res = f_q ^ w_q; alu_mask = MASK_Z; end
            OP_INCF:  begin alu_res = f_q + DATA_WIDTH'(1); alu_mask = MASK_Z; end
            OP_DECF:  begin alu_res = f_q - DATA_WIDTH'(1); alu_mask = MASK_Z; end
            OP_COMF:  begin alu_res = ~f_q; alu_mask = MASK_Z; end
            OP_SWAPF: begin alu_res = {f_q[NIB-1:0], f_q[DATA_WIDTH-1:NIB]}; end
            OP_RLF: begin
                alu_res           = {f_q[DATA_WIDTH-2:0], s_q[FLAG_C]};
                alu_mask          = MASK_C;
                alu_flags[FLAG_C] = f_q[DATA_WIDTH-1];
            end
            OP_RRF: begin
                alu_res           = {s_q[FLAG_C], f_q[DATA_WIDTH-1:1]};
                alu_mask          = MASK_C;
                alu_flags[FLAG_C] = f_q[0];
            end
`ifdef RFC_BITOPS_EN
            OP_BCF: begin alu_res = f_q & ~(DATA_WIDTH'(1) << bit_q); alu_to_file = 1'b1; end
            OP_BSF: begin alu_res = f_q | (DATA_WIDTH'(1) << bit_q); alu_to_file = 1'b1; end
`else
            default: alu_illegal = 1'b1;
`endif
        endcase
        alu_flags[FLAG_Z] = (alu_res == '0);
        status_new = (s_q & ~DATA_WIDTH'(alu_mask)) | DATA_WIDTH'(alu_flags & alu_mask);
    end

    // Q-phase sequencer, request capture, writeback outputs and W register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            ready_q          <= 1'b1;
            op_q             <= '0;
            dest_q           <= 1'b0;
            f_q              <= '0;
            s_q              <= '0;
            w_q              <= '0;
            w_wb_q           <= 1'b0;
            bus.writeCommand <= CMD_NONE;
            bus.fileAddr     <= '0;
            bus.writeDataIn  <= '0;
            bus.statusIn     <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
`ifdef RFC_BITOPS_EN
            bit_q            <= '0;
`endif
        end else begin
            bus.writeCommand <= CMD_NONE;
            done             <= 1'b0;
            err              <= 1'b0;
            if (wLoadEn) begin
                w_q <= wLoadData;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= Q1;
                    end
                end
                Q1: state <= Q2;
                Q2: begin
                    f_q   <= bus.regfileIn;
                    s_q   <= bus.statusCur;
                    state <= Q3;
                end
                Q3: begin
                    bus.writeDataIn <= alu_res;
                    bus.statusIn    <= status_new;
                    done            <= 1'b1;
                    ready_q         <= 1'b1;
                    state           <= Q4;
                    if (alu_illegal) begin
                        err    <= 1'b1;
                        w_wb_q <= 1'b0;
                    end else if (alu_to_file) begin
                        w_wb_q <= 1'b0;
                        // a data write to STATUS overrides any flag update
                        bus.writeCommand <= ((|alu_mask) && (bus.fileAddr != STATUS_ADDR))
                                            ? CMD_FILE_STATUS : CMD_FILE;
                    end else begin
                        w_wb_q           <= 1'b1;
                        bus.writeCommand <= (|alu_mask) ? CMD_STATUS : CMD_NONE;
                    end
                end
                Q4: begin
                    if (w_wb_q) begin
                        w_q <= bus.writeDataIn;
                    end
                    state <= accept ? Q1 : IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (accept) begin
                op_q         <= bus.reqOp;
                dest_q       <= bus.reqDest;
                bus.fileAddr <= bus.reqAddr;
                ready_q      <= 1'b0;
`ifdef RFC_BITOPS_EN
                bit_q        <= bus.reqBit;
`endif
            end
        end
    end
endmodule
